// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port 16-bit word memory behind a two-state access FSM.
// A request sampled in IDLE is latched, then completes after WAIT_CYCLES extra wait
// states (WAIT_CYCLES+1 BUSY cycles in total).
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst        - synchronous active-high reset
//   addr       - 16-bit word address from the CPU
//   rd, wr     - read / write request, sampled only in IDLE
//   wr_data    - write data, sampled with wr
//   data       - read data register; updated only when a read completes
//   RAM_ready  - high while idle; data is valid for the last completed read
//   err        - one-cycle pulse after completion of a bad access
//                (address out of range, or rd and wr both high)
module mem_ctrl #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 2   // legal range 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] wr_data,
  output logic [15:0] data,
  output logic        RAM_ready,
  output logic        err
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] data_q;
  logic        op_wr_q;
  logic        conflict_q;   // rd and wr were both high when the access started
  logic        err_q;

  logic                 start;
  logic                 done;
  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;

  // Contents are deliberately never reset.
  logic [15:0] mem [Depth];

  assign start    = (state_q == StIdle) && (rd || wr);
  assign done     = (state_q == StBusy) && (cnt_q == 4'd0);
  // Shifting rather than slicing keeps this legal when ADDR_BITS == 16.
  assign in_range = (addr_q >> ADDR_BITS) == 16'd0;
  assign idx      = addr_q[ADDR_BITS-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rd || wr) state_d = StBusy;
      StBusy: if (cnt_q == 4'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: RAM_ready comes straight from the state flop, so there is no path from rd/wr.
  always_comb begin
    RAM_ready = (state_q == StIdle);
    data      = data_q;
    err       = err_q;
  end

  // Access datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      addr_q     <= 16'd0;
      wdata_q    <= 16'd0;
      data_q     <= 16'd0;
      op_wr_q    <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= done && (conflict_q || !in_range);
      if (start) begin
        addr_q     <= addr;
        wdata_q    <= wr_data;
        op_wr_q    <= wr;          // rd+wr together is treated as a write
        conflict_q <= rd && wr;
        cnt_q      <= 4'(WAIT_CYCLES);
      end else if (state_q == StBusy && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (done && !op_wr_q) begin
        data_q <= in_range ? mem[idx] : 16'h0000;
      end
    end
  end

  // Memory write port; reset on the completing edge aborts the commit.
  always_ff @(posedge clk) begin
    if (!rst && done && op_wr_q && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wr_data, data;
  logic        rd, wr, ready, err;

  // Second instance built with zero wait states
  logic [15:0] addr1, wr_data1, data1;
  logic        rd1, wr1, ready1, err1;

  int n_cmp = 0;
  int n_err = 0;
  int lows;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .wr_data   (wr_data),
    .data      (data),
    .RAM_ready (ready),
    .err       (err)
  );

  mem_ctrl #(.ADDR_BITS(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr1),
    .rd        (rd1),
    .wr        (wr1),
    .wr_data   (wr_data1),
    .data      (data1),
    .RAM_ready (ready1),
    .err       (err1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts samples with RAM_ready low, starting at the current one, until it rises.
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready) break;
      n++;
      step();
    end
    if (!ready) check("ready_timeout", 16'(ready), 16'd1);
  endtask

  // Issue one request, then scramble inputs while busy (must be ignored).
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int n);
    rd = r; wr = w; addr = a; wr_data = d;
    step();
    rd = 1'b0; wr = 1'b0; addr = 16'h0001; wr_data = 16'hDEAD;
    wait_ready(n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; wr_data = 16'h0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; wr_data1 = 16'h0;
    step(); step();
    rst = 1'b0;
    check("rst_ready", 16'(ready), 16'd1);
    check("rst_data", data, 16'h0000);
    check("rst_err", 16'(err), 16'd0);

    // Write FF00 to 0, read it back
    access(1'b0, 1'b1, 16'h0000, 16'hFF00, lows);
    check("wr0_lows", 16'(lows), 16'd3);
    check("wr0_err", 16'(err), 16'd0);
    check("wr0_data_unch", data, 16'h0000);
    access(1'b1, 1'b0, 16'h0000, 16'h0000, lows);
    check("rd0_lows", 16'(lows), 16'd3);
    check("rd0_data", data, 16'hFF00);
    check("rd0_err", 16'(err), 16'd0);

    // Write 00FF to 1, then back-to-back reads with rd held high
    access(1'b0, 1'b1, 16'h0001, 16'h00FF, lows);
    rd = 1'b1; addr = 16'h0000;
    step();
    addr = 16'h0001;        // changes while busy must not affect the current read
    wait_ready(lows);
    check("b2b_lows_a", 16'(lows), 16'd3);
    check("b2b_data_a", data, 16'hFF00);
    step();                 // one idle cycle, then the held request restarts
    check("b2b_restart", 16'(ready), 16'd0);
    rd = 1'b0;
    wait_ready(lows);
    check("b2b_lows_b", 16'(lows), 16'd3);
    check("b2b_data_b", data, 16'h00FF);

    // Out-of-range read
    access(1'b1, 1'b0, 16'h0100, 16'h0000, lows);
    check("oor_data", data, 16'h0000);
    check("oor_err", 16'(err), 16'd1);
    step();
    check("oor_err_clr", 16'(err), 16'd0);
    access(1'b1, 1'b0, 16'h0000, 16'h0000, lows);
    check("oor_rd0", data, 16'hFF00);
    check("oor_rd0_err", 16'(err), 16'd0);

    // Reset aborts a pending write
    access(1'b0, 1'b1, 16'h0005, 16'h0BAD, lows);
    wr = 1'b1; addr = 16'h0005; wr_data = 16'h1234;
    step();                 // first BUSY cycle
    wr = 1'b0;
    step();                 // second BUSY cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", 16'(ready), 16'd1);
    check("abort_data", data, 16'h0000);
    check("abort_err", 16'(err), 16'd0);
    access(1'b0, 1'b1, 16'h0004, 16'hAAAA, lows);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, lows);
    check("abort_lows", 16'(lows), 16'd3);
    check("abort_rd5", data, 16'h0BAD);
    access(1'b1, 1'b0, 16'h0004, 16'h0000, lows);
    check("abort_rd4", data, 16'hAAAA);

    // Out-of-range write must be discarded, not aliased onto addr 5
    access(1'b0, 1'b1, 16'h0105, 16'hDEAD, lows);
    check("oorw_err", 16'(err), 16'd1);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, lows);
    check("oorw_rd5", data, 16'h0BAD);

    // rd and wr together: write plus error
    access(1'b1, 1'b1, 16'h0002, 16'h5A5A, lows);
    check("both_err", 16'(err), 16'd1);
    check("both_data_unch", data, 16'h0BAD);
    access(1'b1, 1'b0, 16'h0002, 16'h0000, lows);
    check("both_rd2", data, 16'h5A5A);
    check("both_rd2_err", 16'(err), 16'd0);

    // Reset wins over a same-cycle request
    rst = 1'b1; rd = 1'b1; addr = 16'h0002;
    step();
    rst = 1'b0; rd = 1'b0;
    check("rst_prio_ready", 16'(ready), 16'd1);
    check("rst_prio_data", data, 16'h0000);

    // Zero-wait-state instance
    wr1 = 1'b1; addr1 = 16'h0003; wr_data1 = 16'hBEEF;
    step();
    wr1 = 1'b0;
    check("w0_wr_busy", 16'(ready1), 16'd0);
    step();
    check("w0_wr_ready", 16'(ready1), 16'd1);
    check("w0_wr_err", 16'(err1), 16'd0);
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("w0_rd_busy", 16'(ready1), 16'd0);
    step();
    check("w0_rd_ready", 16'(ready1), 16'd1);
    check("w0_rd_data", data1, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 8, number of implemented word-address bits (2^ADDR_BITS x 16-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states inserted per access (legal range 0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 addr  input  16  word address from the CPU.
REQ-006 rd  input  1  read request, sampled only in IDLE.
REQ-007 wr  input  1  write request, sampled only in IDLE.
REQ-008 wr_data  input  16  write data, sampled with wr.
REQ-009 data  output  16  read data register to the CPU.
REQ-010 RAM_ready  output  1  high = controller idle and data valid for last completed read.
REQ-011 err  output  1  one-cycle pulse flagging a bad access at completion.

Function
REQ-012 The FSM SHALL have states IDLE and BUSY only; the wait-state counter SHALL be 4 bits.
REQ-013 In IDLE, RAM_ready SHALL be 1; in BUSY, RAM_ready SHALL be 0 (registered output, no combinational path from rd/wr).
REQ-014 On an edge in IDLE with rd=1 or wr=1, the block SHALL latch addr, wr_data and op, load counter with WAIT_CYCLES, and enter BUSY.
REQ-015 In BUSY, the counter SHALL decrement each cycle; on the edge where counter==0 the access SHALL complete and FSM SHALL return to IDLE.
REQ-016 Latency: request sampled at edge N -> RAM_ready high after edge N+WAIT_CYCLES+1; RAM_ready low for exactly WAIT_CYCLES+1 cycles.
REQ-017 Read completion SHALL load data with mem[latched addr[ADDR_BITS-1:0]] on the same edge RAM_ready rises; data SHALL hold until the next read completes.
REQ-018 Write completion SHALL write latched wr_data to mem[latched addr]; data SHALL be unchanged by writes.
REQ-019 rd and wr both high SHALL be treated as a write, with err pulsed at completion.
REQ-020 Out-of-range address (any of addr[15:ADDR_BITS] nonzero): write SHALL be discarded, read SHALL return 16'h0000, err SHALL pulse at completion.
REQ-021 err SHALL be 1 only in the cycle after the completing edge, otherwise 0.
REQ-022 rd/wr/addr/wr_data changes while BUSY SHALL be ignored; a request held high across completion SHALL start a new access on the first IDLE edge.
REQ-023 Read-after-write to the same address SHALL return the newly written value.
REQ-024 Memory array contents SHALL NOT be reset and SHALL be undefined until written.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, counter=0, data=16'h0000, RAM_ready=1, err=0.
REQ-026 rst during BUSY SHALL abort the access; a pending write SHALL NOT be committed.
REQ-027 rst SHALL take priority over rd/wr in the same cycle.

Verification
REQ-028 Write 16'hFF00 to addr 0, then read addr 0 (WAIT_CYCLES=2) -> RAM_ready low 3 cycles per access, data=16'hFF00 on RAM_ready rise, err=0.
REQ-029 Write 16'h00FF to addr 1, read addr 0 then addr 1 back-to-back with rd held high -> data 16'hFF00 then 16'h00FF, one IDLE cycle between accesses.
REQ-030 Read addr 16'h0100 (ADDR_BITS=8) -> data=16'h0000, err pulses 1 cycle; then read addr 16'h0000 -> unchanged 16'hFF00.
REQ-031 Write 16'h1234 to addr 5, assert rst in its second BUSY cycle, then read addr 5 after re-write of 16'hAAAA to addr 4 -> addr 5 never shows 16'h1234; data=16'h0000 right after reset.
REQ-032 rd=wr=1, addr 2, wr_data 16'h5A5A -> err pulse, subsequent read of addr 2 returns 16'h5A5A.
REQ-033 WAIT_CYCLES=0 build: any access -> RAM_ready low exactly 1 cycle.
